// File: rtl/red_pitaya_sys_pkg.sv
// red_pitaya_sys_pkg
// Shared definitions for the system-bus initiator and its counter.
// Contents:
//   DEF_AW / DEF_DW : default bus address / data widths
//   CNT_W           : width of the timeout and poll-attempt counters (TMO <= 65535)
//   sys_state_t     : initiator FSM states
//   RSP_*           : response codes reported on rsp_code_o
package red_pitaya_sys_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    STRB = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } sys_state_t;

  localparam logic [1:0] RSP_OK        = 2'd0;
  localparam logic [1:0] RSP_ERR       = 2'd1;
  localparam logic [1:0] RSP_TMO       = 2'd2;
  localparam logic [1:0] RSP_POLL_FAIL = 2'd3;

endpackage

// File: rtl/red_pitaya_sys_tmo_cnt.sv
// red_pitaya_sys_tmo_cnt
// Clearable cycle counter that saturates at LIMIT-1 and flags when it is there.
// Used for the ack timeout and for counting poll attempts.
// Ports:
//   clk_i  : clock
//   rstn_i : asynchronous active-low reset
//   clr    : synchronous clear (wins over inc)
//   inc    : count one step
//   hit    : counter currently equals LIMIT-1
module red_pitaya_sys_tmo_cnt
  import red_pitaya_sys_pkg::*;
#(
  parameter int LIMIT = 255
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clr,
  input  logic inc,
  output logic hit
);

  logic [CNT_W-1:0] cnt;

  assign hit = (cnt == CNT_W'(LIMIT - 1));

  // Count up while asked to, but park at the compare value so a stuck
  // inc can never wrap the counter back below LIMIT-1.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !hit) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/red_pitaya_sys_initiator.sv
// red_pitaya_sys_initiator
// Turns one command (valid/ready) into a single access on the house-keeping
// system bus and returns the outcome as one response (valid/ready).
// Every access is guarded by an ack timeout of TMO cycles.
// Optional feature macro: RED_PITAYA_SYS_INIT_POLL_EN (read polling with
// mask/match, up to POLL_MAX attempts, code 3 on exhaustion).
// Ports:
//   clk_i, rstn_i                 : clock, asynchronous active-low reset
//   cmd_valid_i/cmd_ready_o       : command handshake
//   cmd_write_i/addr_i/wdata_i    : command fields, latched on accept
//   cmd_poll_i/mask_i/match_i     : poll fields (feature only)
//   rsp_valid_o/rsp_ready_i       : response handshake
//   rsp_rdata_o/rsp_code_o        : response data and code (RSP_*)
//   busy_o                        : high outside IDLE
//   sys_addr_o/wdata_o/wen_o/ren_o: bus request, one-cycle strobes
//   sys_rdata_i/err_i/ack_i       : bus reply
module red_pitaya_sys_initiator
  import red_pitaya_sys_pkg::*;
#(
  parameter int AW  = DEF_AW,
  parameter int DW  = DEF_DW,
  parameter int TMO = 255
`ifdef RED_PITAYA_SYS_INIT_POLL_EN
  , parameter int POLL_MAX = 16
`endif
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_write_i,
  input  logic [AW-1:0] cmd_addr_i,
  input  logic [DW-1:0] cmd_wdata_i,
`ifdef RED_PITAYA_SYS_INIT_POLL_EN
  input  logic          cmd_poll_i,
  input  logic [DW-1:0] cmd_mask_i,
  input  logic [DW-1:0] cmd_match_i,
`endif
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [DW-1:0] rsp_rdata_o,
  output logic [1:0]    rsp_code_o,
  output logic          busy_o,
  output logic [AW-1:0] sys_addr_o,
  output logic [DW-1:0] sys_wdata_o,
  output logic          sys_wen_o,
  output logic          sys_ren_o,
  input  logic [DW-1:0] sys_rdata_i,
  input  logic          sys_err_i,
  input  logic          sys_ack_i
);

  sys_state_t state;
  logic       write_q;

  // Timeout counter restarts in the strobe cycle of every attempt and only
  // advances while waiting without an ack.
  logic tmo_clr;
  logic tmo_inc;
  logic tmo_hit;

  assign tmo_clr = (state == STRB);
  assign tmo_inc = (state == WAIT) && !sys_ack_i;

  red_pitaya_sys_tmo_cnt #(.LIMIT(TMO)) u_tmo_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr    (tmo_clr),
    .inc    (tmo_inc),
    .hit    (tmo_hit)
  );

  // poll_miss: this ack is an OK read whose data does not match yet.
  // poll_last: the attempt just finished was the final allowed one.
  logic poll_miss;
  logic poll_last;

`ifdef RED_PITAYA_SYS_INIT_POLL_EN
  logic          poll_q;
  logic [DW-1:0] mask_q;
  logic [DW-1:0] match_q;
  logic          poll_clr;
  logic          poll_inc;

  assign poll_miss = poll_q && !write_q && ((sys_rdata_i & mask_q) != match_q);
  assign poll_clr  = (state == IDLE) && cmd_valid_i;
  assign poll_inc  = (state == WAIT) && sys_ack_i && !sys_err_i && poll_miss && !poll_last;

  red_pitaya_sys_tmo_cnt #(.LIMIT(POLL_MAX)) u_poll_cnt (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clr    (poll_clr),
    .inc    (poll_inc),
    .hit    (poll_last)
  );

  // Poll parameters are captured with the command and held for all attempts.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      poll_q  <= 1'b0;
      mask_q  <= '0;
      match_q <= '0;
    end else if (state == IDLE && cmd_valid_i) begin
      poll_q  <= cmd_poll_i;
      mask_q  <= cmd_mask_i;
      match_q <= cmd_match_i;
    end
  end
`else
  assign poll_miss = 1'b0;
  assign poll_last = 1'b0;
`endif

  // Main FSM with all outputs registered. Strobes are set on the transition
  // into STRB so they are high for exactly that one cycle. An ack is only
  // looked at in WAIT, so stale acks in STRB and late acks in RESP/IDLE
  // fall through untouched.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state       <= IDLE;
      write_q     <= 1'b0;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_code_o  <= RSP_OK;
      busy_o      <= 1'b0;
      sys_addr_o  <= '0;
      sys_wdata_o <= '0;
      sys_wen_o   <= 1'b0;
      sys_ren_o   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i) begin
            sys_addr_o  <= cmd_addr_i;
            sys_wdata_o <= cmd_wdata_i;
            write_q     <= cmd_write_i;
            sys_wen_o   <= cmd_write_i;
            sys_ren_o   <= !cmd_write_i;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b1;
            state       <= STRB;
          end
        end
        STRB: begin
          sys_wen_o <= 1'b0;
          sys_ren_o <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          if (sys_ack_i) begin
            if (sys_err_i) begin
              rsp_rdata_o <= '0;
              rsp_code_o  <= RSP_ERR;
              rsp_valid_o <= 1'b1;
              state       <= RESP;
            end else if (poll_miss && !poll_last) begin
              sys_ren_o <= 1'b1;
              state     <= STRB;
            end else if (poll_miss) begin
              rsp_rdata_o <= sys_rdata_i;
              rsp_code_o  <= RSP_POLL_FAIL;
              rsp_valid_o <= 1'b1;
              state       <= RESP;
            end else begin
              rsp_rdata_o <= write_q ? '0 : sys_rdata_i;
              rsp_code_o  <= RSP_OK;
              rsp_valid_o <= 1'b1;
              state       <= RESP;
            end
          end else if (tmo_hit) begin
            rsp_rdata_o <= '0;
            rsp_code_o  <= RSP_TMO;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
            busy_o      <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/red_pitaya_sys_initiator.md
Name: red_pitaya_sys_initiator

Overview:
- System-bus initiator: turns single commands into one register access on the house-keeping-style system bus (sys_addr/wdata/wen/ren in; rdata/err/ack back).
- Used by on-FPGA sequencers (boot-time config, self-test) to drive any bus responder without the PS.
- Command and response sides each use a valid/ready handshake.
- Guards every access with an ack timeout.

Parameters:
- AW, 32, bus address width.
- DW, 32, bus data width.
- TMO, 255, maximum cycles to wait for sys_ack after the strobe; legal range 1..65535.
- POLL_MAX, 16, maximum read attempts in poll mode (feature only).

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid&ready
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_addr_i  in  AW  target address
- cmd_wdata_i  in  DW  write data
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid&ready
- rsp_rdata_o  out  DW  read data; 0 for writes, errors and timeouts
- rsp_code_o  out  2  0 OK, 1 ERR, 2 TIMEOUT, 3 POLL_FAIL
- busy_o  out  1  high in any state except IDLE
- sys_addr_o  out  AW  bus address
- sys_wdata_o  out  DW  bus write data
- sys_wen_o  out  1  write strobe, one cycle
- sys_ren_o  out  1  read strobe, one cycle
- sys_rdata_i  in  DW  bus read data
- sys_err_i  in  1  bus error
- sys_ack_i  in  1  bus acknowledge

Behaviour:
- Single clock domain: clk_i.
- Reset is asynchronous, active-low on rstn_i; all flops are cleared immediately when rstn_i falls.
- Reset values:
  - All outputs 0, except cmd_ready_o = 1.
  - State = IDLE.
  - Timeout counter = 0.
- Reset mid-transaction: the access is abandoned and no response is produced. A late sys_ack_i after reset is ignored because the FSM is in IDLE.
- States:
  - IDLE:
    - cmd_ready_o = 1.
    - On cmd_valid_i, latch addr, wdata and write into sys_addr_o, sys_wdata_o and the internal write flag; go to STRB.
  - STRB (exactly 1 cycle):
    - Assert sys_wen_o if the command is a write, otherwise sys_ren_o.
    - Clear the counter; go to WAIT.
    - sys_ack_i sampled in this cycle is ignored as stale.
  - WAIT:
    - Strobes are 0; sys_addr_o and sys_wdata_o stay stable.
    - On sys_ack_i: capture sys_rdata_i (reads only, else 0); code = 1 if sys_err_i, else 0; go to RESP.
    - Otherwise the counter increments. When counter == TMO-1 without ack: code = 2, rdata = 0, go to RESP.
    - If ack arrives in the same cycle as the counter reaching TMO-1, ack wins.
  - RESP:
    - rsp_valid_o = 1; rdata and code are held stable until rsp_ready_i.
    - On rsp_ready_i, go to IDLE. cmd_ready_o rises the next cycle, so there is no same-cycle back-to-back accept.
    - sys_ack_i in RESP or IDLE (late ack after timeout) is ignored.
- Latency, with a responder that acks 1 cycle after the strobe:
  - Accept at cycle N, strobe at N+1, ack at N+2, rsp_valid_o at N+3.
  - Minimum throughput is one command per 4 cycles.
- cmd_ready_o = 0 in STRB, WAIT and RESP. cmd_valid_i is a don't-care there, and command fields are not re-sampled.
- sys_addr_o and sys_wdata_o keep their last value in IDLE; they are not zeroed.

Optional Feature:
- Macro: RED_PITAYA_SYS_INIT_POLL_EN.
- Defined:
  - Adds ports cmd_poll_i (in 1), cmd_mask_i (in DW) and cmd_match_i (in DW), latched on accept.
  - For a read with poll set: after an OK ack, if (rdata & mask) == match, respond code 0 with that rdata.
  - Otherwise return to STRB and re-issue the read, up to POLL_MAX attempts total.
  - On exhaustion, respond code 3 with the last rdata.
  - ERR or TIMEOUT on any attempt terminates polling immediately with that code.
  - poll is ignored for writes.
- Not defined: the ports are absent, code 3 is never produced, and the attempt counter is not synthesised.

Decomposition:
- Shared package red_pitaya_sys_pkg holds:
  - FSM state enum (IDLE, STRB, WAIT, RESP).
  - rsp_code constants RSP_OK, RSP_ERR, RSP_TMO, RSP_POLL_FAIL.
  - Default bus widths.
- One natural sub-module: red_pitaya_sys_tmo_cnt, a clearable saturating cycle counter with TMO compare, reused for the poll attempt counter.

Test Plan:
- Write 0x0000_00A5 to 0x18, responder acks 1 cycle after strobe -> sys_wen_o high for exactly 1 cycle with addr 0x18; rsp code 0, rdata 0, rsp_valid_o at accept+3.
- Read 0x00, responder returns 0x0000_0001 -> sys_ren_o 1 cycle, rsp_rdata_o 0x1, code 0; with rsp_ready_i held low 5 cycles, the response stays stable and cmd_ready_o stays 0.
- No ack, TMO = 8 -> code 2, rdata 0 after 8 WAIT cycles; an ack injected 3 cycles later is ignored and the next command completes normally.
- Ack with sys_err_i = 1 on read 0x40 -> code 1, rdata 0; ack arriving exactly on the TMO-1 cycle -> code 0.
- rstn_i dropped asynchronously during WAIT -> all outputs are reset values that cycle, busy_o 0, no rsp_valid_o.
- (POLL_EN) Poll 0x20, mask 0x1, match 0x1; responder returns 0, 0, 1 -> three ren strobes, code 0, rdata 1; with all reads returning 0 and POLL_MAX = 4 -> four strobes, code 3.
